// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// The master drives the controls; the counter (slave) returns count, tc and ovf.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] max_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, load, load_data, max_val, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, load, load_data, max_val, clr_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with a run-time inclusive bound [0, max_val].
// Supports wrap or saturate at the bounds, a terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0
) (
  input logic                  clk,
  input logic                  reset,
  param_updown_counter_if.slave bus
);
  localparam logic SAT = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             evt;

  // Next state: compare before any add/subtract so no result exceeds WIDTH bits.
  always_comb begin
    count_d = count_q;
    evt     = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_data > bus.max_val) ? bus.max_val : bus.load_data;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q < bus.max_val) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          evt     = 1'b1;
          count_d = SAT ? bus.max_val : '0;
        end
      end else begin
        if (count_q == '0) begin
          evt     = 1'b1;
          count_d = SAT ? '0 : bus.max_val;
        end else if (count_q > bus.max_val) begin
          // Bound was lowered under us: snap to it quietly.
          count_d = bus.max_val;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d  = evt;
    ovf_d = evt | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a wrap and a saturate instance (WIDTH=4)
// share the same stimulus; each vector lists the expected state of both after the edge.
module tb_param_updown_counter;
  localparam int unsigned W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  param_updown_counter_if #(.WIDTH(W)) bus_w ();
  param_updown_counter_if #(.WIDTH(W)) bus_s ();

  param_updown_counter #(.WIDTH(W), .SATURATE(0)) dut_w (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_w.slave)
  );

  param_updown_counter #(.WIDTH(W), .SATURATE(1)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] ldd;
    logic [W-1:0] mx;
    logic         en;
    logic         up;
    logic         clr;
    logic [W-1:0] cw;
    logic         tw;
    logic         ow;
    logic [W-1:0] cs;
    logic         ts;
    logic         os;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int rst, ld, ldd, mx, en, up, clr,
                             input int cw, tw, ow, cs, ts, os);
    vec_t r;
    r.rst = 1'(rst); r.ld = 1'(ld); r.ldd = W'(ldd); r.mx = W'(mx);
    r.en = 1'(en); r.up = 1'(up); r.clr = 1'(clr);
    r.cw = W'(cw); r.tw = 1'(tw); r.ow = 1'(ow);
    r.cs = W'(cs); r.ts = 1'(ts); r.os = 1'(os);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ld, input logic [W-1:0] ldd, mx,
                       input logic en, up, clr);
    @(negedge clk);
    reset = rst;
    bus_w.load = ld; bus_w.load_data = ldd; bus_w.max_val = mx;
    bus_w.en = en; bus_w.up = up; bus_w.clr_ovf = clr;
    bus_s.load = ld; bus_s.load_data = ldd; bus_s.max_val = mx;
    bus_s.en = en; bus_s.up = up; bus_s.clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus_w.en = 0; bus_w.up = 0; bus_w.load = 0; bus_w.load_data = '0;
    bus_w.max_val = '0; bus_w.clr_ovf = 0;
    bus_s.en = 0; bus_s.up = 0; bus_s.load = 0; bus_s.load_data = '0;
    bus_s.max_val = '0; bus_s.clr_ovf = 0;

    //                    rst ld ldd mx en up clr   cw tw ow  cs ts os
    vecs.push_back(v(1, 0,  0, 15, 0, 0, 0,   0, 0, 0,  0, 0, 0)); // reset
    vecs.push_back(v(0, 1,  9, 15, 0, 0, 0,   9, 0, 0,  9, 0, 0)); // load 9
    vecs.push_back(v(0, 1, 10, 11, 0, 0, 0,  10, 0, 0, 10, 0, 0)); // wrap up
    vecs.push_back(v(0, 0,  0, 11, 1, 1, 0,  11, 0, 0, 11, 0, 0));
    vecs.push_back(v(0, 0,  0, 11, 1, 1, 0,   0, 1, 1, 11, 1, 1));
    vecs.push_back(v(0, 0,  0, 11, 1, 1, 0,   1, 0, 1, 11, 1, 1));
    vecs.push_back(v(0, 0,  0, 11, 0, 1, 1,   1, 0, 0, 11, 0, 0)); // clr_ovf
    vecs.push_back(v(0, 1,  1,  5, 0, 0, 0,   1, 0, 0,  1, 0, 0)); // wrap down
    vecs.push_back(v(0, 0,  0,  5, 1, 0, 0,   0, 0, 0,  0, 0, 0));
    vecs.push_back(v(0, 0,  0,  5, 1, 0, 0,   5, 1, 1,  0, 1, 1));
    vecs.push_back(v(0, 0,  0,  5, 1, 0, 0,   4, 0, 1,  0, 1, 1));
    vecs.push_back(v(0, 0,  0,  5, 0, 0, 1,   4, 0, 0,  0, 0, 0));
    vecs.push_back(v(0, 1, 14, 15, 0, 0, 0,  14, 0, 0, 14, 0, 0)); // saturate
    vecs.push_back(v(0, 0,  0, 15, 1, 1, 0,  15, 0, 0, 15, 0, 0));
    vecs.push_back(v(0, 0,  0, 15, 1, 1, 0,   0, 1, 1, 15, 1, 1));
    vecs.push_back(v(0, 0,  0, 15, 1, 1, 0,   1, 0, 1, 15, 1, 1));
    vecs.push_back(v(0, 0,  0, 15, 1, 1, 0,   2, 0, 1, 15, 1, 1));
    vecs.push_back(v(0, 0,  0, 15, 1, 0, 0,   1, 0, 1, 14, 0, 1)); // reverse
    vecs.push_back(v(0, 1, 13,  7, 0, 0, 0,   7, 0, 1,  7, 0, 1)); // load clamp
    vecs.push_back(v(0, 1, 12, 15, 0, 0, 1,  12, 0, 0, 12, 0, 0));
    vecs.push_back(v(0, 0,  0,  3, 1, 0, 0,   3, 0, 0,  3, 0, 0)); // lowered bound
    vecs.push_back(v(0, 0,  0,  0, 1, 1, 0,   0, 1, 1,  0, 1, 1)); // max_val=0
    vecs.push_back(v(0, 0,  0,  0, 1, 0, 0,   0, 1, 1,  0, 1, 1));
    vecs.push_back(v(0, 0,  0,  0, 1, 1, 1,   0, 1, 1,  0, 1, 1)); // set beats clr
    vecs.push_back(v(0, 0,  0,  0, 0, 1, 1,   0, 0, 0,  0, 0, 0));
    vecs.push_back(v(1, 1,  9, 15, 1, 1, 0,   0, 0, 0,  0, 0, 0)); // reset beats load
    vecs.push_back(v(0, 1, 15, 15, 0, 0, 0,  15, 0, 0, 15, 0, 0));
    vecs.push_back(v(1, 0,  0, 15, 1, 1, 0,   0, 0, 0,  0, 0, 0)); // reset beats event
    vecs.push_back(v(0, 1, 12, 15, 0, 0, 0,  12, 0, 0, 12, 0, 0));
    vecs.push_back(v(0, 0,  0,  3, 1, 1, 0,   0, 1, 1,  3, 1, 1)); // up above bound

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].ldd, vecs[i].mx,
            vecs[i].en, vecs[i].up, vecs[i].clr);
      check($sformatf("v%0d_count_w", i), int'(bus_w.count), int'(vecs[i].cw));
      check($sformatf("v%0d_tc_w",    i), int'(bus_w.tc),    int'(vecs[i].tw));
      check($sformatf("v%0d_ovf_w",   i), int'(bus_w.ovf),   int'(vecs[i].ow));
      check($sformatf("v%0d_count_s", i), int'(bus_s.count), int'(vecs[i].cs));
      check($sformatf("v%0d_tc_s",    i), int'(bus_s.tc),    int'(vecs[i].ts));
      check($sformatf("v%0d_ovf_s",   i), int'(bus_s.ovf),   int'(vecs[i].os));
    end

    // Hold with en=0: count stays, tc stays low.
    drive(1'b0, 1'b1, W'(5), W'(7), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, W'(0), W'(7), 1'b0, 1'b1, 1'b0);
      check($sformatf("hold%0d_count_w", k), int'(bus_w.count), 5);
      check($sformatf("hold%0d_tc_w", k),    int'(bus_w.tc),    0);
    end

    // Direction flip every cycle: 5 -> 6 -> 5 -> 6, no dead cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, W'(0), W'(7), 1'b1, (k % 2 == 0), 1'b0);
      check($sformatf("flip%0d_count_s", k), int'(bus_s.count), (k % 2 == 0) ? 6 : 5);
    end

    // Full wrap pass from 0 to max_val=7 and back to 0; tc only on the wrap.
    drive(1'b0, 1'b1, W'(0), W'(7), 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b0, W'(0), W'(7), 1'b1, 1'b1, 1'b0);
      check($sformatf("pass%0d_count_w", k), int'(bus_w.count), k % 8);
      check($sformatf("pass%0d_tc_w", k),    int'(bus_w.tc),    (k == 8) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
